// File: rtl/ahb_pkg.sv
// Shared AHB encodings, master FSM states and the latched command payload.
package ahb_pkg;

    localparam int unsigned AHB_AW = 32;
    localparam int unsigned AHB_DW = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    typedef enum logic [2:0] {
        MST_IDLE    = 3'd0,
        MST_REQ     = 3'd1,
        MST_ADDR    = 3'd2,
        MST_DATA    = 3'd3,
        MST_BACKOFF = 3'd4
    } mst_state_e;

    typedef struct packed {
        logic              write;
        logic [AHB_AW-1:0] addr;
        logic [AHB_DW-1:0] wdata;
    } mst_cmd_t;

    // RETRY and SPLIT both ask the master to give up the bus and re-arbitrate.
    function automatic logic is_retry(input logic [1:0] resp);
        return (resp == HRESP_RETRY) || (resp == HRESP_SPLIT);
    endfunction

endpackage

// File: rtl/ahb_master_interface_if.sv
// AHB master-side bus signals (arbiter request/grant plus address/data phases).
interface ahb_master_interface_if;
    import ahb_pkg::*;

    logic              hbusreq;
    logic              hgrant;
    logic [AHB_AW-1:0] haddr;
    logic              hwrite;
    logic [1:0]        htrans;
    logic [AHB_DW-1:0] hwdata;
    logic [AHB_DW-1:0] hrdata;
    logic              hready;
    logic [1:0]        hresp;

    modport master (
        output hbusreq, haddr, hwrite, htrans, hwdata,
        input  hgrant, hrdata, hready, hresp
    );

    modport slave (
        input  hbusreq, haddr, hwrite, htrans, hwdata,
        output hgrant, hrdata, hready, hresp
    );

endinterface

// File: rtl/ahb_mst_timeout.sv
// Data-phase wait-state watchdog; only built with AHB_MST_TIMEOUT_EN.
module ahb_mst_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic count_en,
    output logic expired_c
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count consecutive waiting cycles; any non-waiting cycle clears.
    always_comb begin
        cnt_d = '0;
        if (count_en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive waiting cycle.
    assign expired_c = count_en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ahb_master_interface.sv
// AHB single-transfer master: local read/write commands to NONSEQ transfers,
// with RETRY/SPLIT re-arbitration. Optional wait-state timeout via the
// AHB_MST_TIMEOUT_EN macro.
module ahb_master_interface
    import ahb_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 4
`ifdef AHB_MST_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [AHB_AW-1:0]     cmd_addr,
    input  logic [AHB_DW-1:0]     cmd_wdata,
    output logic                  resp_valid,
    output logic [AHB_DW-1:0]     resp_rdata,
    output logic                  resp_err,
    ahb_master_interface_if.master bus
);

    localparam int unsigned RCW = $clog2(MAX_RETRY + 1);

    mst_state_e state_q, state_d;
    mst_cmd_t   cmd_q, cmd_d;
    logic [RCW-1:0]    retry_cnt_q, retry_cnt_d;
    logic              hbusreq_q, hbusreq_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [AHB_AW-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [AHB_DW-1:0] hwdata_q, hwdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [AHB_DW-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              timeout_c;
    logic              retry_done_c;

`ifdef AHB_MST_TIMEOUT_EN
    logic wait_c;

    // Only the address and data phases can stall on hready.
    assign wait_c = ((state_q == MST_ADDR) || (state_q == MST_DATA)) && !bus.hready;

    ahb_mst_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (hclk),
        .rst_n     (hresetn),
        .count_en  (wait_c),
        .expired_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    assign retry_done_c = (retry_cnt_q >= RCW'(MAX_RETRY));
    assign cmd_ready    = (state_q == MST_IDLE);

    // State register.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= MST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MST_IDLE: begin
                if (cmd_valid) state_d = MST_REQ;
            end
            MST_REQ: begin
                if (bus.hgrant && bus.hready) state_d = MST_ADDR;
            end
            MST_ADDR: begin
                if (timeout_c)       state_d = MST_IDLE;
                else if (bus.hready) state_d = MST_DATA;
            end
            MST_DATA: begin
                if (bus.hready)                state_d = MST_IDLE;
                else if (is_retry(bus.hresp))  state_d = MST_BACKOFF;
                else if (timeout_c)            state_d = MST_IDLE;
            end
            MST_BACKOFF: begin
                if (bus.hready) state_d = retry_done_c ? MST_IDLE : MST_REQ;
            end
            default: state_d = MST_IDLE;
        endcase
    end

    // Registered bus/response outputs per state.
    always_comb begin
        cmd_d        = cmd_q;
        retry_cnt_d  = retry_cnt_q;
        hbusreq_d    = hbusreq_q;
        htrans_d     = htrans_q;
        haddr_d      = haddr_q;
        hwrite_d     = hwrite_q;
        hwdata_d     = hwdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            MST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d.write = cmd_write;
                    cmd_d.addr  = cmd_addr;
                    cmd_d.wdata = cmd_wdata;
                    retry_cnt_d = '0;
                    hbusreq_d   = 1'b1;
                end
            end
            MST_REQ: begin
                if (bus.hgrant && bus.hready) begin
                    haddr_d  = cmd_q.addr;
                    hwrite_d = cmd_q.write;
                    htrans_d = HTRANS_NONSEQ;
                end
            end
            MST_ADDR: begin
                if (timeout_c) begin
                    htrans_d     = HTRANS_IDLE;
                    hbusreq_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end else if (bus.hready) begin
                    htrans_d  = HTRANS_IDLE;
                    hbusreq_d = 1'b0;
                    hwdata_d  = cmd_q.wdata;
                end
            end
            MST_DATA: begin
                if (bus.hready) begin
                    // A one-cycle RETRY/SPLIT is malformed and treated as an error.
                    resp_valid_d = 1'b1;
                    if (bus.hresp == HRESP_OKAY) begin
                        resp_err_d   = 1'b0;
                        resp_rdata_d = cmd_q.write ? '0 : bus.hrdata;
                    end else begin
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end
                end else if (is_retry(bus.hresp)) begin
                    retry_cnt_d = retry_cnt_q + RCW'(1);
                end else if (timeout_c) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end
            end
            MST_BACKOFF: begin
                if (bus.hready) begin
                    if (retry_done_c) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        hbusreq_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cmd_q        <= '0;
            retry_cnt_q  <= '0;
            hbusreq_q    <= 1'b0;
            htrans_q     <= HTRANS_IDLE;
            haddr_q      <= '0;
            hwrite_q     <= 1'b0;
            hwdata_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            cmd_q        <= cmd_d;
            retry_cnt_q  <= retry_cnt_d;
            hbusreq_q    <= hbusreq_d;
            htrans_q     <= htrans_d;
            haddr_q      <= haddr_d;
            hwrite_q     <= hwrite_d;
            hwdata_q     <= hwdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.hbusreq = hbusreq_q;
    assign bus.htrans  = htrans_q;
    assign bus.haddr   = haddr_q;
    assign bus.hwrite  = hwrite_q;
    assign bus.hwdata  = hwdata_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_ahb_master_interface.sv
// Directed bench for ahb_master_interface: inputs driven and outputs
// sampled on the falling edge; DUT registers update on the rising edge.
module tb_ahb_master_interface;
    import ahb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_err = 0;
    int n_chk = 0;

    ahb_master_interface_if bus ();

    ahb_master_interface dut (
        .hclk       (clk),
        .hresetn    (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        bus.hgrant  = 1'b1;
        bus.hready  = 1'b1;
        bus.hresp   = HRESP_OKAY;
        bus.hrdata  = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_hbusreq", 32'(bus.hbusreq), 32'd0);
        chk("rst_htrans", 32'(bus.htrans), 32'(HTRANS_IDLE));
        chk("rst_haddr", bus.haddr, 32'h0);
        chk("rst_hwrite", 32'(bus.hwrite), 32'd0);
        chk("rst_hwdata", bus.hwdata, 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Zero-wait write
        issue(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        chk("wr_req_hbusreq", 32'(bus.hbusreq), 32'd1);
        chk("wr_req_htrans", 32'(bus.htrans), 32'(HTRANS_IDLE));
        chk("wr_req_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        chk("wr_addr_htrans", 32'(bus.htrans), 32'(HTRANS_NONSEQ));
        chk("wr_addr_haddr", bus.haddr, 32'h0000_0100);
        chk("wr_addr_hwrite", 32'(bus.hwrite), 32'd1);
        tick();
        chk("wr_data_htrans", 32'(bus.htrans), 32'(HTRANS_IDLE));
        chk("wr_data_hwdata", bus.hwdata, 32'hDEAD_BEEF);
        chk("wr_data_hbusreq", 32'(bus.hbusreq), 32'd0);
        chk("wr_data_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        chk("wr_resp_valid", 32'(resp_valid), 32'd1);
        chk("wr_resp_err", 32'(resp_err), 32'd0);
        chk("wr_resp_rdata", resp_rdata, 32'h0);
        tick();
        chk("wr_resp_pulse", 32'(resp_valid), 32'd0);
        chk("wr_cmd_ready", 32'(cmd_ready), 32'd1);

        // Read with two data-phase wait states
        issue(1'b0, 32'h0000_0204, 32'h0);
        tick();
        chk("rd_addr_htrans", 32'(bus.htrans), 32'(HTRANS_NONSEQ));
        chk("rd_addr_haddr", bus.haddr, 32'h0000_0204);
        chk("rd_addr_hwrite", 32'(bus.hwrite), 32'd0);
        tick();
        bus.hready = 1'b0;
        tick();
        chk("rd_wait1_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        chk("rd_wait2_resp_valid", 32'(resp_valid), 32'd0);
        bus.hready = 1'b1;
        bus.hrdata = 32'h1234_5678;
        tick();
        chk("rd_resp_valid", 32'(resp_valid), 32'd1);
        chk("rd_resp_rdata", resp_rdata, 32'h1234_5678);
        chk("rd_resp_err", 32'(resp_err), 32'd0);
        tick();
        chk("rd_resp_pulse", 32'(resp_valid), 32'd0);

        // Two-cycle ERROR on a write
        issue(1'b1, 32'h0000_0400, 32'h0000_4444);
        tick();
        tick();
        bus.hready = 1'b0;
        bus.hresp  = HRESP_ERROR;
        tick();
        chk("err_wait_resp_valid", 32'(resp_valid), 32'd0);
        bus.hready = 1'b1;
        tick();
        chk("err_resp_valid", 32'(resp_valid), 32'd1);
        chk("err_resp_err", 32'(resp_err), 32'd1);
        chk("err_resp_rdata", resp_rdata, 32'h0);
        bus.hresp = HRESP_OKAY;
        tick();
        chk("err_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("err_resp_pulse", 32'(resp_valid), 32'd0);

        // Grant withheld for five cycles
        bus.hgrant = 1'b0;
        issue(1'b1, 32'h0000_0300, 32'h0000_A5A5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("gnt_wait%0d_hbusreq", i), 32'(bus.hbusreq), 32'd1);
            chk($sformatf("gnt_wait%0d_htrans", i), 32'(bus.htrans), 32'(HTRANS_IDLE));
            if (i == 4) bus.hgrant = 1'b1;
            tick();
        end
        chk("gnt_htrans", 32'(bus.htrans), 32'(HTRANS_NONSEQ));
        chk("gnt_haddr", bus.haddr, 32'h0000_0300);
        tick();
        chk("gnt_hwdata", bus.hwdata, 32'h0000_A5A5);
        tick();
        chk("gnt_resp_valid", 32'(resp_valid), 32'd1);
        chk("gnt_resp_err", 32'(resp_err), 32'd0);
        tick();

        // RETRY once, then OKAY on a read
        issue(1'b0, 32'h0000_0500, 32'h0);
        tick();
        chk("rty_addr1_htrans", 32'(bus.htrans), 32'(HTRANS_NONSEQ));
        chk("rty_addr1_haddr", bus.haddr, 32'h0000_0500);
        tick();
        bus.hready = 1'b0;
        bus.hresp  = HRESP_RETRY;
        tick();
        chk("rty_backoff_hbusreq", 32'(bus.hbusreq), 32'd0);
        chk("rty_backoff_resp_valid", 32'(resp_valid), 32'd0);
        bus.hready = 1'b1;
        tick();
        chk("rty_req_hbusreq", 32'(bus.hbusreq), 32'd1);
        chk("rty_req_htrans", 32'(bus.htrans), 32'(HTRANS_IDLE));
        chk("rty_req_resp_valid", 32'(resp_valid), 32'd0);
        bus.hresp = HRESP_OKAY;
        tick();
        chk("rty_addr2_htrans", 32'(bus.htrans), 32'(HTRANS_NONSEQ));
        chk("rty_addr2_haddr", bus.haddr, 32'h0000_0500);
        tick();
        bus.hrdata = 32'hCAFE_F00D;
        chk("rty_data_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        chk("rty_resp_valid", 32'(resp_valid), 32'd1);
        chk("rty_resp_err", 32'(resp_err), 32'd0);
        chk("rty_resp_rdata", resp_rdata, 32'hCAFE_F00D);
        tick();
        chk("rty_resp_pulse", 32'(resp_valid), 32'd0);

        // SPLIT four times exhausts the retry budget
        issue(1'b1, 32'h0000_0600, 32'h0000_6666);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("spl%0d_htrans", k), 32'(bus.htrans), 32'(HTRANS_NONSEQ));
            chk($sformatf("spl%0d_haddr", k), bus.haddr, 32'h0000_0600);
            tick();
            bus.hready = 1'b0;
            bus.hresp  = HRESP_SPLIT;
            tick();
            bus.hready = 1'b1;
            tick();
            bus.hresp = HRESP_OKAY;
            if (k < 4) begin
                chk($sformatf("spl%0d_rearb_hbusreq", k), 32'(bus.hbusreq), 32'd1);
                chk($sformatf("spl%0d_rearb_resp_valid", k), 32'(resp_valid), 32'd0);
            end else begin
                chk("spl_resp_valid", 32'(resp_valid), 32'd1);
                chk("spl_resp_err", 32'(resp_err), 32'd1);
                chk("spl_resp_rdata", resp_rdata, 32'h0);
                chk("spl_hbusreq", 32'(bus.hbusreq), 32'd0);
            end
        end
        tick();
        chk("spl_cmd_ready", 32'(cmd_ready), 32'd1);

        // Asynchronous reset during the data phase
        issue(1'b1, 32'h0000_0700, 32'h0000_0077);
        tick();
        tick();
        bus.hready = 1'b0;
        chk("ars_pre_hwdata", bus.hwdata, 32'h0000_0077);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ars_hbusreq", 32'(bus.hbusreq), 32'd0);
        chk("ars_htrans", 32'(bus.htrans), 32'(HTRANS_IDLE));
        chk("ars_haddr", bus.haddr, 32'h0);
        chk("ars_hwrite", 32'(bus.hwrite), 32'd0);
        chk("ars_hwdata", bus.hwdata, 32'h0);
        chk("ars_resp_valid", 32'(resp_valid), 32'd0);
        chk("ars_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        rst_n      = 1'b1;
        bus.hready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ars_post%0d_resp_valid", i), 32'(resp_valid), 32'd0);
            chk($sformatf("ars_post%0d_htrans", i), 32'(bus.htrans), 32'(HTRANS_IDLE));
        end

`ifdef AHB_MST_TIMEOUT_EN
        // Data phase stuck with hready low
        issue(1'b0, 32'h0000_0800, 32'h0);
        tick();
        tick();
        bus.hready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("tmo_wait%0d_resp_valid", i), 32'(resp_valid), 32'd0);
        end
        tick();
        chk("tmo_resp_valid", 32'(resp_valid), 32'd1);
        chk("tmo_resp_err", 32'(resp_err), 32'd1);
        chk("tmo_htrans", 32'(bus.htrans), 32'(HTRANS_IDLE));
        bus.hready = 1'b1;
        tick();
        chk("tmo_cmd_ready", 32'(cmd_ready), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
